// File: rtl/mem_stage_if.sv
// M-stage inputs, data-memory port and W-stage outputs of the pipeline memory stage.
interface mem_stage_if;
   logic        valid_M;
   logic        RegWriteM_in;
   logic [1:0]  ResultSrcM_in;
   logic        MemWriteM_in;
   logic [2:0]  funct3M_in;
   logic [31:0] ALUResultM_in;
   logic [31:0] WriteDataM_in;
   logic [31:0] PCPlus4M_in;
   logic [4:0]  RdM_in;

   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   logic        StallM_out;
   logic [31:0] ALUResultW_out;
   logic [31:0] ReadDataW_out;
   logic [31:0] PCPlus4W_out;
   logic [1:0]  ResultSrcW_out;
   logic [4:0]  RdW_out;
   logic        RegWriteW_out;
   logic        misalign_o;

   modport slave (
      input  valid_M, RegWriteM_in, ResultSrcM_in, MemWriteM_in, funct3M_in,
             ALUResultM_in, WriteDataM_in, PCPlus4M_in, RdM_in,
             dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
             StallM_out, ALUResultW_out, ReadDataW_out, PCPlus4W_out,
             ResultSrcW_out, RdW_out, RegWriteW_out, misalign_o
   );

   modport master (
      output valid_M, RegWriteM_in, ResultSrcM_in, MemWriteM_in, funct3M_in,
             ALUResultM_in, WriteDataM_in, PCPlus4M_in, RdM_in,
             dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
             StallM_out, ALUResultW_out, ReadDataW_out, PCPlus4W_out,
             ResultSrcW_out, RdW_out, RegWriteW_out, misalign_o
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: req/gnt/rvalid data-memory handshake, store formatting, load extraction, M->W register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
//
// state    | meaning
// IDLE     | no access outstanding; request issued combinationally for a memop
// WAIT_GNT | request presented, waiting for dmem_gnt_i
// WAIT_R   | load granted, waiting for dmem_rvalid_i
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_R} state_t;

   state_t      state_q, state_d;
   logic [31:0] alu_w_q, alu_w_d;
   logic [31:0] rdata_w_q, rdata_w_d;
   logic [31:0] pc4_w_q, pc4_w_d;
   logic [1:0]  rsrc_w_q, rsrc_w_d;
   logic [4:0]  rd_w_q, rd_w_d;
   logic        regwr_w_q, regwr_w_d;
   logic        misalign_q, misalign_d;

   logic        memop, load, mis_c, mis_op, done, stall, req;
   logic [1:0]  off;
   logic [3:0]  be_c;
   logic [31:0] wdata_c, ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign memop = bus.valid_M & (bus.MemWriteM_in | (bus.ResultSrcM_in == 2'b01));
   assign load  = memop & ~bus.MemWriteM_in;
   assign off   = bus.ALUResultM_in[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      mis_c = 1'b0;
      case (bus.funct3M_in)
         3'b001, 3'b101: mis_c = off[0];
         3'b010:         mis_c = |off;
         default:        mis_c = 1'b0;
      endcase
   end
`else
   assign mis_c = 1'b0;
`endif
   assign mis_op = memop & mis_c;

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      req     = 1'b0;
      case (state_q)
         IDLE: begin
            if (mis_op) begin
               done = 1'b1;
            end else if (memop) begin
               req = 1'b1;
               if (bus.dmem_gnt_i) begin
                  if (load) state_d = WAIT_R;
                  else      done    = 1'b1;
               end else begin
                  state_d = WAIT_GNT;
               end
            end
         end
         WAIT_GNT: begin
            req = memop;
            if (memop & bus.dmem_gnt_i) begin
               if (load) begin
                  state_d = WAIT_R;
               end else begin
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_R: begin
            if (bus.dmem_rvalid_i) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall = memop & ~done;

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = bus.WriteDataM_in;
      case (bus.funct3M_in)
         3'b000: begin
            be_c    = 4'b0001 << off;
            wdata_c = {4{bus.WriteDataM_in[7:0]}};
         end
         3'b001: begin
            be_c    = off[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{bus.WriteDataM_in[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = bus.WriteDataM_in;
         end
      endcase
   end

   always_comb begin
      ld_byte = bus.dmem_rdata_i[7:0];
      case (off)
         2'd0: ld_byte = bus.dmem_rdata_i[7:0];
         2'd1: ld_byte = bus.dmem_rdata_i[15:8];
         2'd2: ld_byte = bus.dmem_rdata_i[23:16];
         2'd3: ld_byte = bus.dmem_rdata_i[31:24];
         default: ld_byte = bus.dmem_rdata_i[7:0];
      endcase
      ld_half = off[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];
      case (bus.funct3M_in)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = bus.dmem_rdata_i;
      endcase
   end

   // A stalled cycle only kills the write-back; payload fields keep their last value.
   always_comb begin
      alu_w_d    = alu_w_q;
      rdata_w_d  = rdata_w_q;
      pc4_w_d    = pc4_w_q;
      rsrc_w_d   = rsrc_w_q;
      rd_w_d     = rd_w_q;
      regwr_w_d  = regwr_w_q;
      misalign_d = 1'b0;
      if (stall) begin
         regwr_w_d = 1'b0;
         rd_w_d    = 5'd0;
      end else begin
         alu_w_d    = bus.ALUResultM_in;
         pc4_w_d    = bus.PCPlus4M_in;
         rsrc_w_d   = bus.ResultSrcM_in;
         rd_w_d     = bus.valid_M ? bus.RdM_in : 5'd0;
         regwr_w_d  = bus.valid_M & bus.RegWriteM_in & ~mis_op;
         rdata_w_d  = (load & done & ~mis_op) ? ld_data : 32'd0;
         misalign_d = mis_op;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         alu_w_q    <= 32'd0;
         rdata_w_q  <= 32'd0;
         pc4_w_q    <= 32'd0;
         rsrc_w_q   <= 2'd0;
         rd_w_q     <= 5'd0;
         regwr_w_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_w_q    <= alu_w_d;
         rdata_w_q  <= rdata_w_d;
         pc4_w_q    <= pc4_w_d;
         rsrc_w_q   <= rsrc_w_d;
         rd_w_q     <= rd_w_d;
         regwr_w_q  <= regwr_w_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.dmem_req_o     = req;
   assign bus.dmem_we_o      = bus.MemWriteM_in;
   assign bus.dmem_addr_o    = {bus.ALUResultM_in[31:2], 2'b00};
   assign bus.dmem_wdata_o   = wdata_c;
   assign bus.dmem_be_o      = be_c;
   assign bus.StallM_out     = stall;
   assign bus.ALUResultW_out = alu_w_q;
   assign bus.ReadDataW_out  = rdata_w_q;
   assign bus.PCPlus4W_out   = pc4_w_q;
   assign bus.ResultSrcW_out = rsrc_w_q;
   assign bus.RdW_out        = rd_w_q;
   assign bus.RegWriteW_out  = regwr_w_q;
   assign bus.misalign_o     = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, store formatting, stalled loads, reset abort, misalign handling.
module tb_mem_stage;
   logic clk;
   logic rst;
   int   vectors;
   int   errs;
   int   stall_cnt;

   mem_stage_if bus ();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc4, input logic [4:0] rd);
      bus.valid_M       = v;
      bus.RegWriteM_in  = rw;
      bus.ResultSrcM_in = rs;
      bus.MemWriteM_in  = mw;
      bus.funct3M_in    = f3;
      bus.ALUResultM_in = alu;
      bus.WriteDataM_in = wd;
      bus.PCPlus4M_in   = pc4;
      bus.RdM_in        = rd;
   endtask

   // Load granted immediately, data returned the following cycle.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
      drive(1'b1, 1'b1, 2'b01, 1'b0, f3, addr, 32'd0, 32'h200, 5'd3);
      bus.dmem_gnt_i    = 1'b1;
      bus.dmem_rvalid_i = 1'b0;
      #1;
      chk({tag, "_stall_req"}, {30'd0, bus.StallM_out, bus.dmem_req_o}, 32'd3);
      step();
      bus.dmem_gnt_i    = 1'b0;
      bus.dmem_rvalid_i = 1'b1;
      bus.dmem_rdata_i  = rdata;
      #1;
      chk({tag, "_done_stall"}, {31'd0, bus.StallM_out}, 32'd0);
      step();
      chk({tag, "_rdata"}, bus.ReadDataW_out, exp);
      bus.dmem_rvalid_i = 1'b0;
   endtask

   initial begin
      vectors = 0;
      errs    = 0;
      rst     = 1'b1;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0);
      bus.dmem_gnt_i    = 1'b0;
      bus.dmem_rvalid_i = 1'b0;
      bus.dmem_rdata_i  = 32'd0;
      step();
      step();
      chk("rst_alu", bus.ALUResultW_out, 32'd0);
      chk("rst_flags", {26'd0, bus.RegWriteW_out, bus.misalign_o, bus.StallM_out,
                        bus.dmem_req_o, bus.ResultSrcW_out}, 32'd0);
      rst = 1'b0;

      // ALU result, no memory op
      drive(1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'd0, 32'h40, 5'd5);
      #1;
      chk("add_stall_req", {30'd0, bus.StallM_out, bus.dmem_req_o}, 32'd0);
      step();
      chk("add_alu", bus.ALUResultW_out, 32'h1234);
      chk("add_rd", bus.RdW_out, 32'd5);
      chk("add_rw", bus.RegWriteW_out, 32'd1);
      chk("add_pc4", bus.PCPlus4W_out, 32'h40);

      // invalid slot -> bubble
      drive(1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 32'h55, 32'd0, 32'h44, 5'd7);
      step();
      chk("bubble_rw_rd", {26'd0, bus.RegWriteW_out, bus.RdW_out}, 32'd0);

      // SB to byte 3, granted at once
      drive(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h48, 5'd0);
      bus.dmem_gnt_i = 1'b1;
      #1;
      chk("sb_req_we_stall", {29'd0, bus.dmem_req_o, bus.dmem_we_o, bus.StallM_out}, 32'h6);
      chk("sb_addr", bus.dmem_addr_o, 32'h100);
      chk("sb_be", bus.dmem_be_o, 32'h8);
      chk("sb_wdata", bus.dmem_wdata_o, 32'hABABABAB);
      step();
      chk("sb_w_rw", bus.RegWriteW_out, 32'd0);

      drive(1'b1, 1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234CDEF, 32'h4C, 5'd0);
      #1;
      chk("sh_be", bus.dmem_be_o, 32'hC);
      chk("sh_wdata", bus.dmem_wdata_o, 32'hCDEFCDEF);
      step();

      drive(1'b1, 1'b0, 2'b00, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h50, 5'd0);
      #1;
      chk("sw_be", bus.dmem_be_o, 32'hF);
      chk("sw_wdata", bus.dmem_wdata_o, 32'hDEADBEEF);
      chk("sw_stall", bus.StallM_out, 32'd0);
      step();
      bus.dmem_gnt_i = 1'b0;

      // LB at 0x102: gnt on cycle 2, stray rvalid on cycle 1, data on cycle 4
      drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 32'h102, 32'd0, 32'h80, 5'd9);
      stall_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         bus.dmem_gnt_i    = (k == 2);
         bus.dmem_rvalid_i = (k == 1) || (k == 4);
         bus.dmem_rdata_i  = (k == 4) ? 32'h00800000 : 32'hFFFFFFFF;
         #1;
         if (bus.StallM_out) stall_cnt++;
         chk($sformatf("lb_req_k%0d", k), bus.dmem_req_o, (k <= 2) ? 32'd1 : 32'd0);
         step();
         if (k < 4) begin
            chk($sformatf("lb_bubble_k%0d", k), {26'd0, bus.RegWriteW_out, bus.RdW_out}, 32'd0);
            chk($sformatf("lb_alu_hold_k%0d", k), bus.ALUResultW_out, 32'h104);
         end
      end
      bus.dmem_rvalid_i = 1'b0;
      chk("lb_stall_cycles", stall_cnt, 32'd4);
      chk("lb_rdata", bus.ReadDataW_out, 32'hFFFFFF80);
      chk("lb_rsrc", bus.ResultSrcW_out, 32'd1);
      chk("lb_rd_rw", {26'd0, bus.RegWriteW_out, bus.RdW_out}, 32'h29);

      do_load("lhu", 3'b101, 32'h202, 32'h8001FFFF, 32'h00008001);
      do_load("lh",  3'b001, 32'h200, 32'h12348001, 32'hFFFF8001);
      do_load("lbu", 3'b100, 32'h101, 32'h0000F000, 32'h000000F0);
      do_load("lw",  3'b010, 32'h300, 32'hCAFEBABE, 32'hCAFEBABE);

      // reset while waiting for read data
      drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h400, 32'd0, 32'h90, 5'd6);
      bus.dmem_gnt_i = 1'b1;
      step();
      bus.dmem_gnt_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_alu", bus.ALUResultW_out, 32'd0);
      chk("rstmid_rdata", bus.ReadDataW_out, 32'd0);
      chk("rstmid_pc4", bus.PCPlus4W_out, 32'd0);
      chk("rstmid_flags", {23'd0, bus.RegWriteW_out, bus.RdW_out, bus.ResultSrcW_out, bus.misalign_o}, 32'd0);
      chk("rstmid_idle_req", bus.dmem_req_o, 32'd1);
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'd0, 32'h0, 5'd0);
      bus.dmem_rvalid_i = 1'b1;
      bus.dmem_rdata_i  = 32'h99999999;
      step();
      chk("late_rvalid_w", {bus.ReadDataW_out[30:0], bus.RegWriteW_out}, 32'd0);
      drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h404, 32'd0, 32'h94, 5'd8);
      #1;
      chk("idle_rvalid_ignored", {30'd0, bus.StallM_out, bus.dmem_req_o}, 32'd3);
      step();
      chk("waitgnt_rvalid_ignored", {30'd0, bus.StallM_out, bus.dmem_req_o}, 32'd3);
      bus.dmem_rvalid_i = 1'b0;
      bus.dmem_gnt_i    = 1'b1;
      step();
      bus.dmem_gnt_i    = 1'b0;
      bus.dmem_rvalid_i = 1'b1;
      bus.dmem_rdata_i  = 32'h11223344;
      step();
      bus.dmem_rvalid_i = 1'b0;
      chk("post_rst_load", bus.ReadDataW_out, 32'h11223344);

      // LW at 0x101
      drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h101, 32'd0, 32'hA0, 5'd4);
`ifdef MEM_MISALIGN_TRAP_EN
      #1;
      chk("mis_req_stall", {30'd0, bus.dmem_req_o, bus.StallM_out}, 32'd0);
      step();
      chk("mis_flag", bus.misalign_o, 32'd1);
      chk("mis_rw", bus.RegWriteW_out, 32'd0);
      drive(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'd0, 32'h0, 5'd0);
      step();
      chk("mis_flag_clear", bus.misalign_o, 32'd0);
`else
      bus.dmem_gnt_i = 1'b1;
      #1;
      chk("lw101_req_stall", {30'd0, bus.dmem_req_o, bus.StallM_out}, 32'd3);
      chk("lw101_addr", bus.dmem_addr_o, 32'h100);
      step();
      bus.dmem_gnt_i    = 1'b0;
      bus.dmem_rvalid_i = 1'b1;
      bus.dmem_rdata_i  = 32'h55667788;
      step();
      bus.dmem_rvalid_i = 1'b0;
      chk("lw101_rdata", bus.ReadDataW_out, 32'h55667788);
      chk("lw101_mis_rw", {30'd0, bus.misalign_o, bus.RegWriteW_out}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
